sprite_addr_cal: RTL and testbench

Per-sprite pixel address calculator for the VGA sprite display path. Each display component (e.g. the Bowser sprite) instantiates one per state buffer. It takes the raster position, the sprite's pattern descriptor and its placement/visibility word. It produces the on-chip sprite-memory address of the pixel under the beam, plus a flag saying whether the sprite covers that pixel. The owning display block uses the flag to mux the palette colour against the background.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_addr_cal.sv | 71 +++++++
 tb/tb_sprite_addr_cal.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite display path: pattern/placement
// words packed by display components and consumed by sprite_addr_cal.
package sprite_pkg;

  localparam int unsigned SPRITE_ADDR_W  = 16;
  localparam int unsigned SPRITE_COORD_W = 10;

  localparam logic [23:0] SPRITE_BG_COLOUR = 24'h202020;

  typedef struct packed {
    logic [15:0] append;  // base address in sprite memory
    logic [15:0] res_h;   // stored row pitch
    logic [15:0] res_v;   // stored rows
    logic [15:0] act_h;   // displayed width
    logic [15:0] act_v;   // displayed height
  } pattern_info_t;

  typedef struct packed {
    logic       visible;
    logic       flip;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] rsvd;
  } sprite_info_t;

endpackage

// File: rtl/sprite_addr_cal.sv
// Per-sprite pixel address calculator: registered sprite-memory address of the
// pixel under the beam plus a coverage flag, one pixel per clock, latency 1.
module sprite_addr_cal
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_W  = SPRITE_ADDR_W,
  parameter int unsigned COORD_W = SPRITE_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [79:0]        pattern_info,
  input  logic [31:0]        sprite_info,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  output logic [ADDR_W-1:0]  addr_output,
  output logic               valid
);

  pattern_info_t pat;
  sprite_info_t  spr;

  logic [COORD_W:0]   col_ext, row_ext;
  logic [COORD_W-1:0] col, row;
  logic [15:0]        wid_h, wid_v, mcol, addr_full;
  logic               hit;

  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic               valid_d, valid_q;

  logic               unused_rsvd;

  assign pat = pattern_info_t'(pattern_info);
  assign spr = sprite_info_t'(sprite_info);

  assign unused_rsvd = ^spr.rsvd;

  always_comb begin
    // Offsets carry a borrow bit; a set MSB means the beam is left of / above the sprite.
    col_ext = {1'b0, hcount} - {1'b0, COORD_W'(spr.x)};
    row_ext = {1'b0, vcount} - {1'b0, COORD_W'(spr.y)};
    col     = col_ext[COORD_W-1:0];
    row     = row_ext[COORD_W-1:0];

    // Displayed size larger than stored size is cropped to the stored size.
    wid_h = (pat.act_h < pat.res_h) ? pat.act_h : pat.res_h;
    wid_v = (pat.act_v < pat.res_v) ? pat.act_v : pat.res_v;

    hit = spr.visible && !col_ext[COORD_W] && !row_ext[COORD_W] &&
          (16'(col) < wid_h) && (16'(row) < wid_v);

    mcol      = spr.flip ? (wid_h - 16'd1 - 16'(col)) : 16'(col);
    addr_full = pat.append + 16'(row) * pat.res_h + mcol;

    valid_d = hit;
    addr_d  = hit ? ADDR_W'(addr_full) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_output = addr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed scoreboard bench for sprite_addr_cal: each step drives one pixel,
// queues the expected {addr, valid} and checks it one clock later.
module tb_sprite_addr_cal;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount, vcount;
  logic [15:0] addr_output;
  logic        valid;

  typedef struct {
    logic [16:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  sprite_addr_cal #(
    .ADDR_W (16),
    .COORD_W(10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pattern_info(pattern_info),
    .sprite_info (sprite_info),
    .hcount      (hcount),
    .vcount      (vcount),
    .addr_output (addr_output),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] mk_pat(input logic [15:0] a, rh, rv, ah, av);
    return {a, rh, rv, ah, av};
  endfunction

  function automatic logic [31:0] mk_spr(input logic vis, fl, input logic [9:0] x, y,
                                         input logic [9:0] rsvd);
    return {vis, fl, x, y, rsvd};
  endfunction

  task automatic step(input logic [9:0] hc, input logic [9:0] vc, input logic [15:0] ea,
                      input logic ev, input string tag);
    sb_entry_t e;
    logic [16:0] got;
    hcount = hc;
    vcount = vc;
    e.exp = {ea, ev};
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got = {addr_output, valid};
    vectors++;
    assert (got === e.exp)
    else begin
      miscompares++;
      $error("FAIL %s: got addr=%0d valid=%0b, expected addr=%0d valid=%0b",
             e.tag, got[16:1], got[0], e.exp[16:1], e.exp[0]);
    end
  endtask

  initial begin
    reset        = 1'b0;
    pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
    sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);

    step(10'd100, 10'd50, 16'd0, 1'b0, "reset_hold0");
    step(10'd100, 10'd50, 16'd0, 1'b0, "reset_hold1");

    reset = 1'b1;
    step(10'd100, 10'd50, 16'd0, 1'b1, "normal_origin");
    step(10'd163, 10'd113, 16'd4095, 1'b1, "normal_corner");
    step(10'd101, 10'd51, 16'd65, 1'b1, "normal_diag");
    step(10'd164, 10'd50, 16'd0, 1'b0, "right_edge");
    step(10'd99, 10'd50, 16'd0, 1'b0, "left_of");
    step(10'd100, 10'd114, 16'd0, 1'b0, "below");
    step(10'd100, 10'd49, 16'd0, 1'b0, "above");

    sprite_info = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'h3ff);
    step(10'd101, 10'd51, 16'd65, 1'b1, "rsvd_ignored");

    sprite_info = mk_spr(1'b0, 1'b0, 10'd100, 10'd50, 10'd0);
    step(10'd120, 10'd60, 16'd0, 1'b0, "invisible");

    sprite_info = mk_spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
    step(10'd100, 10'd50, 16'd63, 1'b1, "flip_origin");
    step(10'd163, 10'd50, 16'd0, 1'b1, "flip_right");
    step(10'd100, 10'd51, 16'd127, 1'b1, "flip_row1");

    pattern_info = mk_pat(16'd4096, 16'd64, 16'd64, 16'd32, 16'd16);
    sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
    step(10'd100, 10'd50, 16'd4096, 1'b1, "base_origin");
    step(10'd131, 10'd65, 16'd5087, 1'b1, "crop_corner");
    step(10'd132, 10'd50, 16'd0, 1'b0, "crop_h_edge");
    step(10'd100, 10'd66, 16'd0, 1'b0, "crop_v_edge");

    sprite_info = mk_spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
    step(10'd100, 10'd50, 16'd4127, 1'b1, "crop_flip");

    // Displayed size bigger than stored: clipped to stored 64x64.
    pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd100, 16'd100);
    sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
    step(10'd163, 10'd113, 16'd4095, 1'b1, "oversize_last");
    step(10'd164, 10'd50, 16'd0, 1'b0, "oversize_h");
    step(10'd100, 10'd114, 16'd0, 1'b0, "oversize_v");

    pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd0);
    step(10'd100, 10'd50, 16'd0, 1'b0, "act_v_zero");
    pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd0, 16'd64);
    step(10'd100, 10'd50, 16'd0, 1'b0, "act_h_zero");

    pattern_info = mk_pat(16'd65530, 16'd64, 16'd64, 16'd64, 16'd64);
    step(10'd101, 10'd50, 16'd65531, 1'b1, "wrap_col");
    step(10'd100, 10'd51, 16'd58, 1'b1, "wrap_row");

    pattern_info = mk_pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
    sprite_info  = mk_spr(1'b1, 1'b0, 10'd1000, 10'd50, 10'd0);
    step(10'd1023, 10'd50, 16'd23, 1'b1, "offscreen_edge");

    sprite_info = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
    reset = 1'b0;
    step(10'd101, 10'd51, 16'd0, 1'b0, "reset_midsprite");
    reset = 1'b1;
    step(10'd101, 10'd51, 16'd65, 1'b1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
